// File: rtl/dt_pkg.sv
// Shared constants and loader state type for the distance-transform front end.
package dt_pkg;
  localparam int DT_IMG_DIM   = 128;
  localparam int DT_STI_WORDS = 1024;
  localparam int DT_STI_W     = 16;

  typedef enum logic [1:0] {FILL, FLUSH, KICK, WAIT} loader_state_t;
endpackage

// File: rtl/dt_bit_packer.sv
// Serial-to-word packer: shifts accepted pixels in MSB-first and flags the last bit of each word.
module dt_bit_packer
  import dt_pkg::*;
#(
  parameter int WORD_W = DT_STI_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      accept,
  input  logic                      pix_data,
  input  logic                      border_mask,
  output logic                      stored_bit,
  output logic [$clog2(WORD_W)-1:0] bit_cnt,
  output logic                      word_done,
  output logic [WORD_W-1:0]         word_next
);
  localparam int CNT_W = $clog2(WORD_W);

  logic [WORD_W-2:0] shift_q;

  assign stored_bit = pix_data & ~border_mask;
  assign word_done  = accept && (bit_cnt == '0);
  // The word including the pixel being accepted now; valid for the write when word_done is high.
  assign word_next  = {shift_q, stored_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      bit_cnt <= CNT_W'(WORD_W - 1);
    end else if (accept) begin
      shift_q <= word_next[WORD_W-2:0];
      bit_cnt <= bit_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/dt_sti_loader.sv
// Loads a serial 128x128 binary image into sti memory, then starts the DT engine and waits for it.
// Build option: DT_LOADER_BORDER_CLR_EN forces the outermost image ring to background.
module dt_sti_loader
  import dt_pkg::*;
#(
  parameter int WORD_W = DT_STI_W,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic              pix_data,
  output logic              pix_ready,
  output logic              sti_we,
  output logic [ADDR_W-1:0] sti_waddr,
  output logic [WORD_W-1:0] sti_wdata,
  output logic              dt_start,
  input  logic              dt_done,
  output logic              busy,
  output logic [14:0]       obj_cnt
);
  localparam int CNT_W = $clog2(WORD_W);

  loader_state_t     state;
  logic [ADDR_W-1:0] word_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              accept;
  logic              border_mask;
  logic              stored_bit;
  logic              word_done;
  logic [WORD_W-1:0] word_next;

  assign accept = pix_valid && pix_ready;

`ifdef DT_LOADER_BORDER_CLR_EN
  logic [6:0] row;
  logic [6:0] col;

  // Column is the word's slot within the row followed by the pixel's offset inside the word.
  assign row         = word_cnt[ADDR_W-1:3];
  assign col         = {word_cnt[2:0], ~bit_cnt};
  assign border_mask = (row == '0) || (row == 7'(DT_IMG_DIM - 1)) ||
                       (col == '0) || (col == 7'(DT_IMG_DIM - 1));
`else
  logic unused_bit_cnt;

  assign unused_bit_cnt = ^bit_cnt;
  assign border_mask    = 1'b0;
`endif

  dt_bit_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .accept      (accept),
    .pix_data    (pix_data),
    .border_mask (border_mask),
    .stored_bit  (stored_bit),
    .bit_cnt     (bit_cnt),
    .word_done   (word_done),
    .word_next   (word_next)
  );

  // The FSM gates pix_ready so the shared sti memory is untouched between KICK and dt_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      pix_ready <= 1'b1;
      sti_we    <= 1'b0;
      sti_waddr <= '0;
      sti_wdata <= '0;
      dt_start  <= 1'b0;
      busy      <= 1'b0;
      obj_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      sti_we   <= 1'b0;
      dt_start <= 1'b0;
      if (word_done) begin
        sti_we    <= 1'b1;
        sti_waddr <= word_cnt;
        sti_wdata <= word_next;
        word_cnt  <= word_cnt + 1'b1;
      end
      if (accept && stored_bit) begin
        obj_cnt <= obj_cnt + 15'd1;
      end
      case (state)
        FILL: begin
          if (word_done && (word_cnt == '1)) begin
            state     <= FLUSH;
            pix_ready <= 1'b0;
          end
        end
        FLUSH: begin
          state    <= KICK;
          dt_start <= 1'b1;
          busy     <= 1'b1;
        end
        KICK: begin
          state <= WAIT;
        end
        WAIT: begin
          if (dt_done) begin
            state     <= FILL;
            pix_ready <= 1'b1;
            busy      <= 1'b0;
            obj_cnt   <= '0;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end
endmodule
